// File: rtl/decode_window_ctrl.sv
// -----------------------------------------------------------------------------
// decode_window_ctrl
//
// Byte-alignment controller between the fetch queue and the D-stage
// prefix/opcode decoders. Holds up to 32 instruction bytes in a shift buffer
// and presents a 16-byte decode window whose byte 0 is always the next
// undecoded byte. Each accepted consume retires consume_len bytes from the
// front of the window. Each accepted fetch appends 16 bytes behind the last
// valid byte.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   fetch_valid    fetch_line carries 16 new bytes
//   fetch_line     fetched bytes, lowest address at [127:120]
//   fetch_ready    buffer has room for a full line (count <= 16)
//   flush          redirect: drop every buffered byte
//   packet         decode window, buffer byte k at [127-8k:120-8k]
//   packet_valid   window holds at least 15 bytes (maximum instruction length)
//   consume_valid  decoder finished the instruction at window byte 0
//   consume_len    length of that instruction, 1..15
//   byte_count     number of valid buffered bytes, 0..32
//   len_err        sticky illegal-consume flag
//
// Optional feature macro: DECODE_WINDOW_LEN_CHECK_EN
//   defined     -> len_err sets on a zero-length consume, or on a consume longer
//                  than the buffered byte count, while packet_valid is high.
//                  That consume is dropped. len_err clears only on reset.
//   not defined -> len_err is tied to 0. Zero-length consumes are still dropped.
//
// All outputs come from registered state only. There is no combinational
// path from any input to any output.
// -----------------------------------------------------------------------------
module decode_window_ctrl (
    input  logic         clk,
    input  logic         reset,
    input  logic         fetch_valid,
    input  logic [127:0] fetch_line,
    output logic         fetch_ready,
    input  logic         flush,
    output logic [127:0] packet,
    output logic         packet_valid,
    input  logic         consume_valid,
    input  logic [3:0]   consume_len,
    output logic [5:0]   byte_count,
    output logic         len_err
);

    localparam int BUF_BYTES  = 32;
    localparam int LINE_BYTES = 16;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [7:0] byte_buf_reg  [0:BUF_BYTES-1];
    logic [7:0] byte_buf_next [0:BUF_BYTES-1];
    logic [5:0] count_reg;
    logic [5:0] count_next;

    // Fetch line split into bytes; index 0 is the lowest address.
    logic [7:0] fetch_bytes [0:LINE_BYTES-1];

    // Handshake decode
    logic       fetch_accept;
    logic       consume_accept;
    logic       len_error;
    logic [3:0] shift_len;
    logic [5:0] append_base;

    // -------------------------------------------------------------------------
    // Outputs, all derived from registered state
    // -------------------------------------------------------------------------
    assign fetch_ready  = (count_reg <= 6'd16);
    assign packet_valid = (count_reg >= 6'd15);
    assign byte_count   = count_reg;

    // Vacated buffer slots are always zero, so the window needs no masking
    // against count_reg. Bytes at or beyond the count already read 0.
    for (genvar gi = 0; gi < LINE_BYTES; gi++) begin : g_packet
        assign packet[127-8*gi -: 8] = byte_buf_reg[gi];
    end

    for (genvar gi = 0; gi < LINE_BYTES; gi++) begin : g_fetch_bytes
        assign fetch_bytes[gi] = fetch_line[127-8*gi -: 8];
    end

    // -------------------------------------------------------------------------
    // Consume legality
    // -------------------------------------------------------------------------
`ifdef DECODE_WINDOW_LEN_CHECK_EN
    // A consume offered while the window is valid is illegal in two cases:
    // it has zero length, or it is longer than the bytes actually buffered.
    assign len_error = consume_valid & packet_valid &
                       ((consume_len == 4'd0) | ({2'b00, consume_len} > count_reg));
`else
    assign len_error = 1'b0;
`endif

    assign fetch_accept   = fetch_valid & fetch_ready;
    assign consume_accept = consume_valid & packet_valid &
                            (consume_len != 4'd0) & ~len_error;

    always_comb begin
        shift_len   = 4'd0;
        append_base = count_reg;
        count_next  = count_reg;
        if (consume_accept) begin
            shift_len = consume_len;
        end
        // count_reg >= shift_len holds whenever a consume is accepted,
        // because packet_valid guarantees at least 15 bytes.
        append_base = count_reg - {2'b00, shift_len};
        // Fetch is only accepted at count <= 16, so the sum stays <= 32.
        count_next  = append_base + (fetch_accept ? 6'd16 : 6'd0);
    end

    // -------------------------------------------------------------------------
    // Per-byte next value: shift left by shift_len, then overlay the fetch
    // line at append_base .. append_base+15.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < BUF_BYTES; gi++) begin : g_byte_next
        logic [6:0] src_idx;
        logic [7:0] shifted_byte;
        logic [5:0] pos;
        logic [5:0] rel;
        logic       in_fetch;

        assign src_idx      = 7'(gi) + {3'b000, shift_len};
        // Positions that shift in from above the top of the buffer become 0.
        assign shifted_byte = (src_idx < 7'(BUF_BYTES)) ? byte_buf_reg[src_idx[4:0]] : 8'h00;

        assign pos      = 6'(gi);
        assign rel      = pos - append_base;
        assign in_fetch = fetch_accept & (pos >= append_base) & (rel < 6'(LINE_BYTES));

        assign byte_buf_next[gi] = in_fetch ? fetch_bytes[rel[3:0]] : shifted_byte;
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= 6'd0;
            for (int i = 0; i < BUF_BYTES; i++) begin
                byte_buf_reg[i] <= 8'h00;
            end
        end else if (flush) begin
            // Redirect: the in-flight fetch line and any consume are dropped.
            count_reg <= 6'd0;
            for (int i = 0; i < BUF_BYTES; i++) begin
                byte_buf_reg[i] <= 8'h00;
            end
        end else begin
            count_reg <= count_next;
            for (int i = 0; i < BUF_BYTES; i++) begin
                byte_buf_reg[i] <= byte_buf_next[i];
            end
        end
    end

`ifdef DECODE_WINDOW_LEN_CHECK_EN
    logic len_err_reg;

    // Sticky until reset. A flush cycle holds the flag and records nothing new.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_err_reg <= 1'b0;
        end else if (!flush && len_error) begin
            len_err_reg <= 1'b1;
        end
    end

    assign len_err = len_err_reg;
`else
    assign len_err = 1'b0;
`endif

endmodule
